// File: rtl/tod_pkg.sv
// Shared types and constants for the time-of-day tick generator.
package tod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } tod_state_e;

    localparam int unsigned TOD_DIV_DEFAULT = 100;

endpackage

// File: rtl/tod_tick_gen_if.sv
// Divisor register bus of the tick generator: write port plus active-divisor readback.
interface tod_tick_gen_if #(
    parameter int unsigned P_DIV_WIDTH = 16
) ();

    logic                   REG_SELECT;
    logic                   REG_WRITE;
    logic [P_DIV_WIDTH-1:0] DATA_IN;
    logic [P_DIV_WIDTH-1:0] DIVISOR_Q;

    modport master (
        output REG_SELECT,
        output REG_WRITE,
        output DATA_IN,
        input  DIVISOR_Q
    );

    modport slave (
        input  REG_SELECT,
        input  REG_WRITE,
        input  DATA_IN,
        output DIVISOR_Q
    );

endinterface

// File: rtl/tod_tick_gen.sv
// Programmable tick generator feeding the time-of-day counter increment.
//   state    | meaning
//   ST_IDLE  | stopped, divisor updates applied on every edge
//   ST_ARMED | enabled, waiting for SYNC_PULSE to start
//   ST_RUN   | phase counter running, TICK_Q every D cycles
module tod_tick_gen
    import tod_pkg::*;
#(
    parameter int unsigned P_DIV_WIDTH   = 16,
    parameter int unsigned P_DIV_DEFAULT = TOD_DIV_DEFAULT,
    parameter bit          P_SYNC_START  = 1'b0
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          ENABLE,
    input  logic          SYNC_PULSE,
    tod_tick_gen_if.slave reg_bus,
    output logic          TICK_Q,
    output logic          RUNNING_Q
);

    typedef logic [P_DIV_WIDTH-1:0] div_t;

    tod_state_e state_q;
    tod_state_e state_d;
    div_t       cnt_q;
    div_t       cnt_d;
    div_t       div_q;
    div_t       div_d;
    div_t       pend_val_q;
    div_t       pend_val_d;
    div_t       div_eff;
    logic       pend_q;
    logic       pend_d;
    logic       tick_d;
    logic       xfer;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        tick_d     = 1'b0;
        xfer       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                xfer = 1'b1;
                if (ENABLE) begin
                    state_d = P_SYNC_START ? ST_ARMED : ST_RUN;
                end
            end
            ST_ARMED: begin
                xfer = 1'b1;
                if (SYNC_PULSE) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                xfer = SYNC_PULSE || (cnt_q == div_t'(1));
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping ENABLE wins over everything; a pending divisor waits for IDLE.
        if (!ENABLE) begin
            state_d = ST_IDLE;
            if (state_q == ST_RUN) begin
                xfer = 1'b0;
            end
        end

        if (xfer && pend_q) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
        end

        // A write on a transfer edge lands in pending and waits for the next one.
        if (reg_bus.REG_SELECT && reg_bus.REG_WRITE) begin
            pend_d     = 1'b1;
            pend_val_d = reg_bus.DATA_IN;
        end

        div_eff = (div_d == '0) ? div_t'(1) : div_d;

        if (state_d == ST_RUN) begin
            if ((state_q != ST_RUN) || SYNC_PULSE) begin
                cnt_d = div_eff;
            end else if (cnt_q == div_t'(1)) begin
                tick_d = 1'b1;
                cnt_d  = div_eff;
            end else begin
                cnt_d = cnt_q - div_t'(1);
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= div_t'(P_DIV_DEFAULT);
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            TICK_Q     <= 1'b0;
            RUNNING_Q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            TICK_Q     <= tick_d;
            RUNNING_Q  <= (state_d == ST_RUN);
        end
    end

    assign reg_bus.DIVISOR_Q = div_q;

endmodule

// File: tb/tb_tod_tick_gen.sv
// Bench for tod_tick_gen: free-start and sync-start instances, tick edges scored against queues.
module tb_tod_tick_gen;

    logic clock = 1'b0;
    logic reset;
    logic enable0;
    logic enable1;
    logic sync0;
    logic sync1;
    logic tick0;
    logic tick1;
    logic running0;
    logic running1;

    int n      = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int e;
    int q0[$];
    int q1[$];

    tod_tick_gen_if #(.P_DIV_WIDTH(16)) bus0 ();
    tod_tick_gen_if #(.P_DIV_WIDTH(16)) bus1 ();

    tod_tick_gen #(
        .P_DIV_WIDTH  (16),
        .P_DIV_DEFAULT(100),
        .P_SYNC_START (1'b0)
    ) dut0 (
        .CLOCK     (clock),
        .RESET     (reset),
        .ENABLE    (enable0),
        .SYNC_PULSE(sync0),
        .reg_bus   (bus0),
        .TICK_Q    (tick0),
        .RUNNING_Q (running0)
    );

    tod_tick_gen #(
        .P_DIV_WIDTH  (16),
        .P_DIV_DEFAULT(100),
        .P_SYNC_START (1'b1)
    ) dut1 (
        .CLOCK     (clock),
        .RESET     (reset),
        .ENABLE    (enable1),
        .SYNC_PULSE(sync1),
        .reg_bus   (bus1),
        .TICK_Q    (tick1),
        .RUNNING_Q (running1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    // Advance one edge, then score any tick against the head of the matching queue.
    task automatic step();
        @(posedge clock);
        #1;
        n++;
        if (tick0 === 1'b1) begin
            if (q0.size() == 0) chk("tick0_unexpected", n, -1);
            else                chk("tick0_edge", n, q0.pop_front());
        end
        if (tick1 === 1'b1) begin
            if (q1.size() == 0) chk("tick1_unexpected", n, -1);
            else                chk("tick1_edge", n, q1.pop_front());
        end
    endtask

    task automatic start_run(input int div, output int e_out);
        enable0 = 1'b0;
        step();
        bus0.REG_SELECT = 1'b1;
        bus0.REG_WRITE  = 1'b1;
        bus0.DATA_IN    = 16'(div);
        step();
        bus0.REG_SELECT = 1'b0;
        bus0.REG_WRITE  = 1'b0;
        step();
        chk("div_loaded", bus0.DIVISOR_Q, div);
        enable0 = 1'b1;
        e_out   = n + 1;
    endtask

    initial begin
        reset   = 1'b1;
        enable0 = 1'b1;
        enable1 = 1'b1;
        sync0   = 1'b0;
        sync1   = 1'b0;
        bus0.REG_SELECT = 1'b1;
        bus0.REG_WRITE  = 1'b1;
        bus0.DATA_IN    = 16'd7;
        bus1.REG_SELECT = 1'b1;
        bus1.REG_WRITE  = 1'b1;
        bus1.DATA_IN    = 16'd7;
        step();
        step();
        chk("rst_tick", tick0, 0);
        chk("rst_running", running0, 0);
        chk("rst_divisor", bus0.DIVISOR_Q, 100);
        chk("rst_running_sync", running1, 0);
        chk("rst_divisor_sync", bus1.DIVISOR_Q, 100);
        reset   = 1'b0;
        enable0 = 1'b0;
        enable1 = 1'b0;
        bus0.REG_SELECT = 1'b0;
        bus0.REG_WRITE  = 1'b0;
        bus1.REG_SELECT = 1'b0;
        bus1.REG_WRITE  = 1'b0;
        step();
        chk("rst_no_pending", bus0.DIVISOR_Q, 100);

        // Divisor 4: ticks 4, 8, 12 edges after entry.
        start_run(4, e);
        q0.push_back(e + 4);
        q0.push_back(e + 8);
        q0.push_back(e + 12);
        step();
        chk("run_entry", running0, 1);
        repeat (13) step();
        chk("d4_ticks_drained", q0.size(), 0);

        // Divisor 10, write 3 mid-period: current period holds, then period 3.
        start_run(10, e);
        q0.push_back(e + 10);
        q0.push_back(e + 20);
        q0.push_back(e + 23);
        q0.push_back(e + 26);
        for (int k = 0; k < 28; k++) begin
            bus0.REG_SELECT = (n == e + 11);
            bus0.REG_WRITE  = (n == e + 11);
            bus0.DATA_IN    = 16'd3;
            step();
            if (n == e + 19) chk("div_hold_10", bus0.DIVISOR_Q, 10);
            if (n == e + 20) chk("div_switch_3", bus0.DIVISOR_Q, 3);
        end
        bus0.REG_SELECT = 1'b0;
        bus0.REG_WRITE  = 1'b0;
        chk("d10_ticks_drained", q0.size(), 0);

        // Divisor 5: sync on terminal count at e+15, then a mid-period sync at e+22.
        start_run(5, e);
        q0.push_back(e + 5);
        q0.push_back(e + 10);
        q0.push_back(e + 20);
        q0.push_back(e + 27);
        for (int k = 0; k < 30; k++) begin
            sync0 = (n == e + 14) || (n == e + 21);
            step();
        end
        sync0 = 1'b0;
        chk("sync_ticks_drained", q0.size(), 0);

        // Divisor 0 acts as 1: TICK_Q high every edge, low on the edge leaving RUN.
        start_run(0, e);
        for (int k = 1; k <= 4; k++) q0.push_back(e + k);
        repeat (5) step();
        enable0 = 1'b0;
        step();
        chk("d1_tick_low", tick0, 0);
        chk("d1_idle", running0, 0);
        chk("d1_ticks_drained", q0.size(), 0);

        // Sync-start instance: armed for 7 edges, first tick 6 edges after sync.
        bus1.REG_SELECT = 1'b1;
        bus1.REG_WRITE  = 1'b1;
        bus1.DATA_IN    = 16'd6;
        step();
        bus1.REG_SELECT = 1'b0;
        bus1.REG_WRITE  = 1'b0;
        step();
        chk("sync_div_loaded", bus1.DIVISOR_Q, 6);
        enable1 = 1'b1;
        e = n;
        q1.push_back(e + 14);
        q1.push_back(e + 20);
        for (int k = 0; k < 22; k++) begin
            sync1 = (n == e + 7);
            step();
            if (n == e + 7) chk("armed_not_running", running1, 0);
            if (n == e + 8) chk("sync_running", running1, 1);
        end
        sync1   = 1'b0;
        enable1 = 1'b0;
        step();
        chk("armed_ticks_drained", q1.size(), 0);

        // Reset mid-RUN with a divisor write pending.
        start_run(4, e);
        step();
        bus0.REG_SELECT = 1'b1;
        bus0.REG_WRITE  = 1'b1;
        bus0.DATA_IN    = 16'd9;
        step();
        bus0.REG_SELECT = 1'b0;
        bus0.REG_WRITE  = 1'b0;
        reset = 1'b1;
        step();
        chk("mid_rst_tick", tick0, 0);
        chk("mid_rst_running", running0, 0);
        chk("mid_rst_divisor", bus0.DIVISOR_Q, 100);
        reset   = 1'b0;
        enable0 = 1'b0;
        step();
        step();
        chk("mid_rst_pending_dropped", bus0.DIVISOR_Q, 100);
        chk("mid_rst_ticks_drained", q0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
